// File: rtl/inv_cipher_iter.sv
// ---------------------------------------------------------------------------
// inv_cipher_iter
//   Iterative AES-128 inverse cipher. One ciphertext block and its key are
//   accepted per transaction; one inverse round is applied per clock through
//   a single shared round datapath, and the plaintext is returned.
//
//   Handshakes: a transfer happens on a rising clk edge where valid and ready
//   are both 1. The producer holds data/valid stable until that edge; ready
//   may be asserted independently of valid.
//
//   Byte order: byte 0 of every 128-bit word is bits [127:120]; the state is
//   column-major, byte i = row (i % 4), column (i / 4).
//
// Ports
//   clk        in   1    rising-edge clock
//   rst        in   1    asynchronous active-low reset
//   data       in   128  ciphertext
//   key        in   128  cipher key
//   in_valid   in   1    data/key valid
//   in_ready   out  1    block can accept a transaction (registered)
//   o          out  128  plaintext (state register)
//   out_valid  out  1    o valid (registered)
//   out_ready  in   1    consumer accepts o
//   dbg_state  out  3    FSM state: 0 IDLE, 1 INIT, 2 ROUND, 3 FINAL, 4 DONE
// ---------------------------------------------------------------------------
module inv_cipher_iter (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] data,
    input  logic [127:0] key,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [127:0] o,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [2:0]   dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_ROUND = 3'd2,
        S_FINAL = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // ---------------- GF(2^8) and byte-level helpers ----------------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (square-and-multiply); maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        r = x;
        for (int i = 0; i < 6; i++) r = gmul(gmul(r, r), x);
        return gmul(r, r);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    // Inverse affine map (rotations by 1, 3 and 6, constant 0x05), then inverse.
    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] y;
        y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        return gf_inv(y);
    endfunction

    // ---------------- inverse round leaves --------------------------------
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] res;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                res[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
            end
        end
        return res;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] res;
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
        return res;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] res;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            res[127-32*c -: 8] = gmul(a0, 8'd14) ^ gmul(a1, 8'd11) ^ gmul(a2, 8'd13) ^ gmul(a3, 8'd9);
            res[119-32*c -: 8] = gmul(a0, 8'd9)  ^ gmul(a1, 8'd14) ^ gmul(a2, 8'd11) ^ gmul(a3, 8'd13);
            res[111-32*c -: 8] = gmul(a0, 8'd13) ^ gmul(a1, 8'd9)  ^ gmul(a2, 8'd14) ^ gmul(a3, 8'd11);
            res[103-32*c -: 8] = gmul(a0, 8'd11) ^ gmul(a1, 8'd13) ^ gmul(a2, 8'd9)  ^ gmul(a3, 8'd14);
        end
        return res;
    endfunction

    // Full combinational schedule: words w[0..43], w[0] in the top 32 bits.
    function automatic logic [1407:0] key_expand(input logic [127:0] k);
        logic [31:0]   w [44];
        logic [31:0]   t;
        logic [7:0]    rcon;
        logic [1407:0] res;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rcon = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])}
                    ^ {rcon, 24'h000000};
                rcon = xtime(rcon);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 44; i++) res[1407-32*i -: 32] = w[i];
        return res;
    endfunction

    // ---------------- registers -------------------------------------------
    state_t         r_state;
    logic [127:0]   r_st;
    logic [127:0]   r_key;
    logic [3:0]     r_rnd;
    logic           r_in_ready;
    logic           r_out_valid;

    state_t         w_state_next;
    logic [127:0]   w_st_next;
    logic [127:0]   w_key_next;
    logic [3:0]     w_rnd_next;

    logic [1407:0]  w_sched;
    logic [127:0]   w_rk;
    logic [127:0]   w_ark;
    logic [127:0]   w_round_mix;
    logic           w_accept;

    assign w_sched = key_expand(r_key);

    // Round-key mux: rk(r) = w[4r..4r+3]; values of rnd above 10 never occur.
    always_comb begin
        w_rk = '0;
        for (int r = 0; r <= 10; r++) begin
            if (r_rnd == 4'(r)) w_rk = w_sched[1407-128*r -: 128];
        end
    end

    // Shared datapath: FINAL takes w_ark, ROUND additionally applies InvMixColumns.
    assign w_ark       = inv_sub_bytes(inv_shift_rows(r_st)) ^ w_rk;
    assign w_round_mix = inv_mix_columns(w_ark);
    assign w_accept    = in_valid & r_in_ready;

    always_comb begin
        w_state_next = r_state;
        w_st_next    = r_st;
        w_key_next   = r_key;
        w_rnd_next   = r_rnd;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_st_next    = data;
                    w_key_next   = key;
                    w_rnd_next   = 4'd10;
                    w_state_next = S_INIT;
                end
            end
            S_INIT: begin
                w_st_next    = r_st ^ w_rk;
                w_rnd_next   = 4'd9;
                w_state_next = S_ROUND;
            end
            S_ROUND: begin
                w_st_next  = w_round_mix;
                w_rnd_next = r_rnd - 4'd1;
                if (r_rnd == 4'd1) w_state_next = S_FINAL;
            end
            S_FINAL: begin
                w_st_next    = w_ark;
                w_state_next = S_DONE;
            end
            S_DONE: begin
                if (r_out_valid && out_ready) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // in_ready / out_valid are registered copies of the next-state decode so
    // they line up exactly with IDLE / DONE (in_ready stays 0 during reset).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_st        <= '0;
            r_key       <= '0;
            r_rnd       <= 4'd0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_st        <= w_st_next;
            r_key       <= w_key_next;
            r_rnd       <= w_rnd_next;
            r_in_ready  <= (w_state_next == S_IDLE);
            r_out_valid <= (w_state_next == S_DONE);
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign o         = r_st;
    assign dbg_state = r_state;

endmodule
